// File: rtl/pcie_cfg_pkg.sv
// Shared PCIe config-space constants, state encodings and
// Device Control field helpers for the config scanner.
package pcie_cfg_pkg;

    typedef enum logic [1:0] {
        SC_IDLE,
        SC_XFER,
        SC_NEXT,
        SC_HOLD
    } scan_state_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_SETUP,
        HS_READ,
        HS_RELEASE
    } hs_state_e;

    localparam logic [9:0] BAR0_DW = 10'd4;
    localparam logic [9:0] BAR1_DW = 10'd5;
    localparam logic [9:0] BAR2_DW = 10'd6;
    localparam logic [9:0] BAR3_DW = 10'd7;
    localparam logic [9:0] BAR4_DW = 10'd8;
    localparam logic [9:0] BAR5_DW = 10'd9;

    localparam int MPS_LSB  = 5;
    localparam int MPS_MSB  = 7;
    localparam int MRRS_LSB = 12;
    localparam int MRRS_MSB = 14;

    localparam logic [2:0] SZ_128B  = 3'b000;
    localparam logic [2:0] SZ_256B  = 3'b001;
    localparam logic [2:0] SZ_512B  = 3'b010;
    localparam logic [2:0] SZ_1024B = 3'b011;
    localparam logic [2:0] SZ_2048B = 3'b100;
    localparam logic [2:0] SZ_4096B = 3'b101;

    function automatic logic [2:0] dc_mps(input logic [31:0] d);
        return d[MPS_MSB:MPS_LSB];
    endfunction

    function automatic logic [2:0] dc_mrrs(input logic [31:0] d);
        return d[MRRS_MSB:MRRS_LSB];
    endfunction

endpackage

// File: rtl/cfg_space_scanner_if.sv
// CFG management read port between the scanner and the PCIe hard core.
interface cfg_space_scanner_if;

    logic [9:0]  o_cfg_dwaddr;
    logic        o_cfg_rd_en;
    logic [31:0] i_cfg_do;
    logic        i_cfg_rd_wr_done;

    modport master (
        output o_cfg_dwaddr,
        output o_cfg_rd_en,
        input  i_cfg_do,
        input  i_cfg_rd_wr_done
    );

    modport slave (
        input  o_cfg_dwaddr,
        input  o_cfg_rd_en,
        output i_cfg_do,
        output i_cfg_rd_wr_done
    );

endinterface

// File: rtl/cfg_rd_handshake.sv
// Single CFG dword read: address setup, strobe, done handshake, timeout.
module cfg_rd_handshake
    import pcie_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  addr,
    cfg_space_scanner_if.master cfg,
    output logic        fin,
    output logic        rd_ok,
    output logic        rd_to,
    output logic        rel_to,
    output logic [31:0] rd_data
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    hs_state_e     state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [9:0]    addr_q, addr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HS_IDLE;
            tmr_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        addr_d  = addr_q;
        fin     = 1'b0;
        rd_ok   = 1'b0;
        rd_to   = 1'b0;
        rel_to  = 1'b0;
        unique case (state_q)
            HS_IDLE: begin
                if (start) state_d = HS_SETUP;
            end
            HS_SETUP: begin
                addr_d  = addr;
                tmr_d   = '0;
                state_d = HS_READ;
            end
            HS_READ: begin
                tmr_d = tmr_q + 1'b1;
                // done wins over a coincident timeout
                if (cfg.i_cfg_rd_wr_done) begin
                    rd_ok   = 1'b1;
                    tmr_d   = '0;
                    state_d = HS_RELEASE;
                end else if (tmr_q == T_LAST) begin
                    rd_to   = 1'b1;
                    tmr_d   = '0;
                    state_d = HS_RELEASE;
                end
            end
            HS_RELEASE: begin
                tmr_d = tmr_q + 1'b1;
                if (!cfg.i_cfg_rd_wr_done) begin
                    fin     = 1'b1;
                    state_d = HS_IDLE;
                end else if (tmr_q == T_LAST) begin
                    rel_to  = 1'b1;
                    fin     = 1'b1;
                    state_d = HS_IDLE;
                end
            end
        endcase
    end

    assign cfg.o_cfg_dwaddr = addr_q;
    assign cfg.o_cfg_rd_en  = (state_q == HS_READ);
    assign rd_data          = cfg.i_cfg_do;

endmodule

// File: rtl/cfg_space_scanner.sv
// Walks a list of config dwords, shadows each one and decodes
// MPS/MRRS from the Device Control entry.
module cfg_space_scanner
    import pcie_cfg_pkg::*;
#(
    parameter int NUM_REGS       = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int REFRESH_CYCLES = 0,
    parameter int DEVCTRL_INDEX  = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic [NUM_REGS*10-1:0] i_addr_list,
    cfg_space_scanner_if.master    cfg,
    output logic [NUM_REGS*32-1:0] o_data,
    output logic [NUM_REGS-1:0]    o_valid,
    output logic [2:0]             o_max_payload,
    output logic [2:0]             o_max_rd_req,
    output logic                   o_busy,
    output logic                   o_scan_done,
    output logic                   o_changed,
    output logic                   o_timeout_err
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int HW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(NUM_REGS - 1);
    localparam logic [IW-1:0] DC_IDX = IW'(DEVCTRL_INDEX);
    localparam logic [HW-1:0] H_LAST = HW'(REFRESH_CYCLES - 1);

    scan_state_e   state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          en_q;
    logic          chg_q;
    logic          err_q;
    logic [2:0]    mps_q, mrrs_q;
    logic [NUM_REGS-1:0]       valid_q;
    logic [NUM_REGS-1:0][31:0] data_q;

    logic        hs_start;
    logic        hs_fin;
    logic        hs_ok;
    logic        hs_rd_to;
    logic        hs_rel_to;
    logic [31:0] hs_data;
    logic [9:0]  cur_addr;

    assign cur_addr = i_addr_list[idx_q*10 +: 10];

    cfg_rd_handshake #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_hs (
        .clk     (clk),
        .rst     (rst),
        .start   (hs_start),
        .addr    (cur_addr),
        .cfg     (cfg),
        .fin     (hs_fin),
        .rd_ok   (hs_ok),
        .rd_to   (hs_rd_to),
        .rel_to  (hs_rel_to),
        .rd_data (hs_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SC_IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        hs_start    = 1'b0;
        o_scan_done = 1'b0;
        o_changed   = 1'b0;
        unique case (state_q)
            SC_IDLE: begin
                idx_d = '0;
                if (i_en && !en_q) begin
                    hs_start = 1'b1;
                    state_d  = SC_XFER;
                end
            end
            SC_XFER: begin
                if (hs_fin) state_d = SC_NEXT;
            end
            SC_NEXT: begin
                if (idx_q == I_LAST) begin
                    o_scan_done = 1'b1;
                    o_changed   = chg_q;
                    idx_d       = '0;
                    hold_d      = '0;
                    if (REFRESH_CYCLES > 0 && i_en) state_d = SC_HOLD;
                    else state_d = SC_IDLE;
                end else begin
                    idx_d    = idx_q + 1'b1;
                    hs_start = 1'b1;
                    state_d  = SC_XFER;
                end
            end
            SC_HOLD: begin
                if (!i_en) begin
                    state_d = SC_IDLE;
                end else if (hold_q == H_LAST) begin
                    idx_d    = '0;
                    hs_start = 1'b1;
                    state_d  = SC_XFER;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= 1'b0;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
            mps_q   <= '0;
            mrrs_q  <= '0;
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            en_q <= i_en;
            if (hs_ok) begin
                data_q[idx_q]  <= hs_data;
                valid_q[idx_q] <= 1'b1;
                if (idx_q == DC_IDX) begin
                    mps_q  <= dc_mps(hs_data);
                    mrrs_q <= dc_mrrs(hs_data);
                end
            end
            // a timed-out read keeps the stale dword but flags it invalid
            if (hs_rd_to) valid_q[idx_q] <= 1'b0;
            if (hs_rd_to || hs_rel_to) err_q <= 1'b1;
            if (o_scan_done) chg_q <= 1'b0;
            else if (hs_ok && hs_data != data_q[idx_q]) chg_q <= 1'b1;
        end
    end

    assign o_data        = data_q;
    assign o_valid       = valid_q;
    assign o_max_payload = mps_q;
    assign o_max_rd_req  = mrrs_q;
    assign o_timeout_err = err_q;
    assign o_busy        = (state_q == SC_XFER) || (state_q == SC_NEXT);

endmodule

// File: tb/tb_cfg_space_scanner.sv
// Randomized bench for cfg_space_scanner with a CFG-port responder
// and a list-level reference model of the shadow registers.
module tb_cfg_space_scanner;

    localparam int N  = 6;
    localparam int TO = 64;
    localparam int RF = 100;
    localparam int DC = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [N*10-1:0] alist;
    logic [N*32-1:0] odata;
    logic [N-1:0]  ovalid;
    logic [2:0]    mps, mrrs;
    logic          busy, sdone, chg, terr;

    cfg_space_scanner_if cif();

    cfg_space_scanner #(
        .NUM_REGS       (N),
        .TIMEOUT_CYCLES (TO),
        .REFRESH_CYCLES (RF),
        .DEVCTRL_INDEX  (DC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_en          (en),
        .i_addr_list   (alist),
        .cfg           (cif),
        .o_data        (odata),
        .o_valid       (ovalid),
        .o_max_payload (mps),
        .o_max_rd_req  (mrrs),
        .o_busy        (busy),
        .o_scan_done   (sdone),
        .o_changed     (chg),
        .o_timeout_err (terr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // CFG core responder: done `lat` cycles into rd_en, held `hold` cycles
    logic [31:0] mem [1024];
    int lat = 2;
    int hold = 1;
    int dead_addr = -1;
    int rd_cnt = 0;
    int hold_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            cif.i_cfg_rd_wr_done <= 1'b0;
            cif.i_cfg_do <= '0;
            hold_left = 0;
        end else if (cif.o_cfg_rd_en && int'(cif.o_cfg_dwaddr) != dead_addr
                     && rd_cnt + 1 == lat) begin
            cif.i_cfg_rd_wr_done <= 1'b1;
            cif.i_cfg_do <= mem[cif.o_cfg_dwaddr];
            hold_left = hold - 1;
        end else if (hold_left > 0) begin
            hold_left--;
        end else begin
            cif.i_cfg_rd_wr_done <= 1'b0;
        end
        rd_cnt = cif.o_cfg_rd_en ? rd_cnt + 1 : 0;
    end

    int n_done, n_rise, rise_w_done, run, max_run, idle_run, last_gap;
    int stray_chg;
    bit prev_rd;

    always @(negedge clk) begin
        if (cif.o_cfg_rd_en) begin
            if (!prev_rd) begin
                n_rise++;
                if (cif.i_cfg_rd_wr_done) rise_w_done++;
            end
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        prev_rd = cif.o_cfg_rd_en;
        if (!busy) idle_run++;
        if (chg && !sdone) stray_chg++;
        if (sdone) begin
            n_done++;
            last_gap = idle_run;
            idle_run = 0;
        end
    end

    task automatic clr();
        n_done = 0;
        n_rise = 0;
        rise_w_done = 0;
        max_run = 0;
    endtask

    // reference model of the shadow registers
    int          addr [N];
    logic [31:0] e_data [N];
    bit          e_valid [N];
    bit          e_err;
    logic [2:0]  e_mps, e_mrrs;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            e_data[k] = '0;
            e_valid[k] = 1'b0;
        end
        e_err = 1'b0;
        e_mps = '0;
        e_mrrs = '0;
    endtask

    task automatic set_list();
        for (int k = 0; k < N; k++) alist[k*10 +: 10] = addr[k][9:0];
    endtask

    task automatic model_scan(output bit ch);
        logic [31:0] w;
        ch = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (addr[k] == dead_addr) begin
                e_valid[k] = 1'b0;
                e_err = 1'b1;
            end else begin
                w = mem[addr[k]];
                if (w != e_data[k]) ch = 1'b1;
                e_data[k] = w;
                e_valid[k] = 1'b1;
                if (k == DC) begin
                    e_mps = w[7:5];
                    e_mrrs = w[14:12];
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] ev;
        for (int k = 0; k < N; k++) begin
            ev[k] = e_valid[k];
            check($sformatf("%s_data%0d", tag, k), odata[k*32 +: 32], e_data[k]);
        end
        check({tag, "_valid"}, 32'(ovalid), 32'(ev));
        check({tag, "_mps"}, 32'(mps), 32'(e_mps));
        check({tag, "_mrrs"}, 32'(mrrs), 32'(e_mrrs));
        check({tag, "_err"}, 32'(terr), 32'(e_err));
    endtask

    task automatic wait_scan(output bit ok, output bit c);
        ok = 1'b0;
        c = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (sdone) begin
                ok = 1'b1;
                c = chg;
            end
        end
        check("scan_done_seen", 32'(ok), 32'd1);
    endtask

    task automatic one_scan(input string tag);
        bit ok, c, ch;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_scan(ok, c);
        model_scan(ch);
        check({tag, "_changed"}, 32'(c), 32'(ch));
        repeat (2) @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, c, ch;
        int r, seen;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hF000_0000 + i;
        for (int k = 0; k < N; k++) addr[k] = 4 + k;
        model_reset();
        rst = 1'b1;
        en = 1'b0;
        alist = '0;
        clr();
        stray_chg = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", 32'(cif.o_cfg_rd_en), 0);
        check("rst_dwaddr", 32'(cif.o_cfg_dwaddr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(sdone), 0);
        check("rst_changed", 32'(chg), 0);
        check("rst_any_data", 32'(|odata), 0);
        check_all("rst");
        set_list();
        rst = 1'b0;

        // basic scan of BAR0..5
        clr();
        one_scan("basic");
        check("basic_rd_en_count", 32'(n_rise), 32'd6);
        check("basic_done_count", 32'(n_done), 32'd1);
        check("basic_e0", odata[31:0], 32'hF000_0004);

        // Device Control decode
        mem[9] = 32'h0000_2040;
        one_scan("devctrl");
        check("dc_mps", 32'(mps), 32'd2);
        check("dc_mrrs", 32'(mrrs), 32'd2);

        // read timeout on entry 2, then sticky error
        clr();
        dead_addr = 6;
        mem[4] = $urandom;
        one_scan("tmo");
        check("tmo_rd_en_run", 32'(max_run), 32'd64);
        check("tmo_rd_en_count", 32'(n_rise), 32'd6);
        dead_addr = -1;
        one_scan("sticky");

        // periodic refresh with i_en held high
        @(negedge clk);
        en = 1'b1;
        clr();
        for (int s = 0; s < 4; s++) begin
            wait_scan(ok, c);
            model_scan(ch);
            check($sformatf("rf_changed%0d", s), 32'(c), 32'(ch));
            @(negedge clk);
            if (s > 0) check($sformatf("rf_gap%0d", s), 32'(last_gap), 32'(RF));
            if (s == 1) begin
                r = $urandom_range(0, N - 1);
                mem[addr[r]] = mem[addr[r]] ^ 32'h0100_0000;
            end
        end
        check_all("rf");
        en = 1'b0;
        seen = n_done;
        repeat (150) @(negedge clk);
        check("rf_stop_busy", 32'(busy), 0);
        check("rf_stop_count", 32'(n_done), 32'(seen));

        // done held high through RELEASE
        clr();
        hold = 5;
        for (int k = 0; k < N; k++) mem[addr[k]] = $urandom;
        one_scan("hold5");
        check("hold5_rd_en_count", 32'(n_rise), 32'd6);
        check("hold5_early_rd", 32'(rise_w_done), 0);

        // random lists, latencies and timeouts
        for (int t = 0; t < 10; t++) begin
            lat = $urandom_range(1, 4);
            hold = $urandom_range(1, 3);
            for (int k = 0; k < N; k++) begin
                addr[k] = $urandom_range(0, 1023);
                mem[addr[k]] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            end
            dead_addr = ($urandom_range(0, 3) == 0) ? addr[$urandom_range(0, N - 1)] : -1;
            set_list();
            one_scan($sformatf("rnd%0d", t));
        end
        dead_addr = -1;
        lat = 2;
        hold = 1;

        // reset while a read is outstanding
        for (int k = 0; k < N; k++) addr[k] = 4 + k;
        set_list();
        dead_addr = 6;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (cif.o_cfg_rd_en && cif.o_cfg_dwaddr == 10'd6) ok = 1'b1;
        end
        check("mid_read_reached", 32'(ok), 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_rd_en", 32'(cif.o_cfg_rd_en), 0);
        check("mid_rst_data", 32'(|odata), 0);
        check("mid_rst_valid", 32'(ovalid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_err", 32'(terr), 0);
        @(negedge clk);
        rst = 1'b0;
        dead_addr = -1;
        model_reset();
        one_scan("post_rst");
        check("stray_changed", 32'(stray_chg), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_space_scanner.md
Name: cfg_space_scanner

Overview:
- Parametrised PCIe configuration-space reader. Walks a run-time list of NUM_REGS config dword addresses over the core's CFG management read port and captures each returned dword into a per-entry shadow register.
- Decodes Max Payload Size and Max Read Request Size from a designated Device Control entry.
- Supports one-shot or periodic refresh, per-read timeout and change detection.
- Sits between the PCIe hard-core CFG interface and the platform control/BAR-decode logic.

Parameters:
NUM_REGS, 8, number of config dwords scanned (1..16)
TIMEOUT_CYCLES, 64, cycles to wait for i_cfg_rd_wr_done before abandoning a read (>=2)
REFRESH_CYCLES, 0, idle cycles between automatic rescans; 0 = one-shot per i_en rising edge
DEVCTRL_INDEX, 7, list index holding the PCIe Device Control/Status dword

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
i_en  in  1  scan enable; a rising edge starts a scan; while high with REFRESH_CYCLES>0, rescans repeat
i_addr_list  in  NUM_REGS*10  dword addresses; entry k = bits [10k+9:10k]; sampled per entry in SETUP
i_cfg_do  in  32  CFG read data
i_cfg_rd_wr_done  in  1  CFG read complete
o_cfg_dwaddr  out  10  CFG dword address
o_cfg_rd_en  out  1  CFG read strobe
o_data  out  NUM_REGS*32  captured dwords; entry k = bits [32k+31:32k]
o_valid  out  NUM_REGS  entry k captured successfully in the most recent attempt
o_max_payload  out  3  Device Control bits [7:5] of entry DEVCTRL_INDEX
o_max_rd_req  out  3  Device Control bits [14:12] of entry DEVCTRL_INDEX
o_busy  out  1  scan in progress
o_scan_done  out  1  one-cycle pulse at end of each scan
o_changed  out  1  one-cycle pulse with o_scan_done if any captured value differs from its previous value
o_timeout_err  out  1  sticky; set on any timeout; cleared only by rst

Behaviour:
- Reset: state IDLE, index 0, o_cfg_dwaddr = 0, o_cfg_rd_en = 0, o_data = 0, o_valid = 0, o_max_payload = 0, o_max_rd_req = 0, o_busy = 0, o_scan_done = 0, o_changed = 0, o_timeout_err = 0, timers = 0. Reset mid-scan aborts immediately; the next cycle shows reset values.
- Edge detect: register i_en; a start occurs on i_en & ~i_en_q.
- IDLE: index <= 0. On start -> SETUP.
- SETUP (1 cycle): o_cfg_dwaddr <= entry[index] address; o_cfg_rd_en = 0; clear timer -> READ.
- READ: o_cfg_rd_en = 1; timer increments each cycle.
  - If done is seen: capture i_cfg_do into o_data[index] and set o_valid[index]. If the new value differs from the old value, set the internal changed flag. -> RELEASE.
  - Else if timer == TIMEOUT_CYCLES-1: clear o_valid[index], keep the old data, set o_timeout_err -> RELEASE.
  - Done and timeout in the same cycle: done wins.
- RELEASE: o_cfg_rd_en = 0; wait for i_cfg_rd_wr_done == 0 (bounded by the same timeout; if it expires, set o_timeout_err) -> NEXT.
- NEXT: if index == NUM_REGS-1, pulse o_scan_done, pulse o_changed if the flag is set, clear the flag, then:
  - go to HOLDOFF if REFRESH_CYCLES > 0 and i_en is high;
  - otherwise go to IDLE.
  - If index < NUM_REGS-1: index + 1 -> SETUP. The index never exceeds NUM_REGS-1; there is no off-by-one extra read.
- HOLDOFF: count REFRESH_CYCLES cycles -> SETUP with index 0. If i_en drops, go to IDLE.
- o_busy = 1 in SETUP, READ, RELEASE and NEXT.
- The first scan after reset always pulses o_changed if any entry is nonzero.
- o_max_payload and o_max_rd_req update in the same cycle the DEVCTRL_INDEX entry is captured.
- i_en falling mid-scan does not abort; the current scan completes.
- Minimum per-entry latency: 4 cycles (SETUP, READ with done on the first cycle, RELEASE with done already low, NEXT).
- Index width: $clog2(NUM_REGS), minimum 1.

Decomposition:
- Shared package pcie_cfg_pkg:
  - state encodings;
  - standard BAR0..5 dword addresses (4..9);
  - DEVCTRL field bit positions (MPS 7:5, MRRS 14:12);
  - MPS/MRRS encoding constants (000 = 128B .. 101 = 4096B).
- One natural sub-module, cfg_rd_handshake: owns the SETUP/READ/RELEASE strobe, the done handshake and the timeout counter. Returns data, ok and timeout pulses to the scanner sequencer.

Test Plan:
- NUM_REGS=6, list 4..9, model returns done 2 cycles after rd_en with data 0xF000_0000+addr -> o_data entry k = 0xF000_0004+k, o_valid = 0x3F, a single o_scan_done pulse, o_changed = 1, exactly 6 rd_en assertions.
- Device Control entry returns 0x0000_2040 -> o_max_payload = 3'b010, o_max_rd_req = 3'b010.
- Model never asserts done for entry 2 (TIMEOUT_CYCLES=64) -> rd_en high for exactly 64 cycles, o_valid[2] = 0, o_timeout_err = 1 and sticky, remaining entries captured.
- REFRESH_CYCLES=100, i_en held high, identical data -> o_scan_done repeats 100 idle cycles apart, o_changed = 0 after the first scan; altering one word -> o_changed = 1 on the next scan only.
- rst asserted while in READ -> next cycle o_cfg_rd_en = 0, o_data = 0, o_valid = 0, o_busy = 0.
- done held high across RELEASE for 5 cycles -> NEXT entered only after done drops; no double capture.
